// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM encoding, the
// default-width FIFO entry layout and a state decode helper.
package imem_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Decode helper so busy has a single definition shared with any checker.
  function automatic logic state_is_busy(input fetch_state_t s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus between the fetch sequencer, the instruction ROM and the decode stage,
// including the branch redirect request coming back from decode/execute.
interface imem_fetch_ctrl_if #(
  parameter int N = 32
);
  logic [N-1:0] imem_pc;
  logic [N-1:0] imem_instr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_instr;
  logic [N-1:0] out_pc;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;

  modport master (
    output imem_pc,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// Small synchronous prefetch FIFO: head read straight from storage registers,
// flush wins over push/pop, push+pop allowed together while full.
module imem_fetch_ctrl_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          push_s;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign dout  = mem_r[rd_ptr_r];

  // A full FIFO only accepts a write when the head leaves in the same cycle.
  assign pop_s  = pop & ~empty;
  assign push_s = push & (~full | pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the ROM, buffers words in a
// prefetch FIFO for decode, services branch redirects and stops at program end.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int N        = 32,
  parameter int INS      = 10,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  imem_fetch_ctrl_if.master      bus,
  output logic                   busy,
  output logic                   done
);

  localparam logic [N-1:0] INS_W   = N'(INS);
  localparam logic [N-1:0] RESET_W = N'(RESET_PC);

  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pc;
  } entry_t;

  fetch_state_t state_r;
  fetch_state_t state_next_s;
  logic [N-1:0] pc_r;
  logic         busy_r;
  logic         done_r;
  logic         full_s;
  logic         empty_s;
  logic         pop_s;
  logic         push_s;
  logic         pc_ok_s;
  logic         target_ok_s;
  entry_t       fifo_in_s;
  entry_t       fifo_out_s;

  assign pc_ok_s     = (pc_r < INS_W);
  assign target_ok_s = (bus.redirect_pc < INS_W);
  assign pop_s       = ~empty_s & bus.out_ready;
  // ROM is only sampled for in-range PCs; a redirect suppresses the fetch.
  assign push_s      = (state_r == RUN) & pc_ok_s & (~full_s | pop_s) & ~bus.redirect_valid;
  assign fifo_in_s   = {bus.imem_instr, pc_r};

  imem_fetch_ctrl_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (push_s),
    .pop   (pop_s),
    .din   (fifo_in_s),
    .dout  (fifo_out_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign bus.imem_pc   = pc_r;
  assign bus.out_valid = ~empty_s;
  assign bus.out_instr = fifo_out_s.instr;
  assign bus.out_pc    = fifo_out_s.pc;
  assign busy          = busy_r;
  assign done          = done_r;

  // Next-state selection; a redirect outranks every other condition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.redirect_valid) begin
          state_next_s = IDLE;
        end else if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          state_next_s = target_ok_s ? RUN : DRAIN;
        end else if (!pc_ok_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (bus.redirect_valid) begin
          state_next_s = target_ok_s ? RUN : DRAIN;
        end else if (empty_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        if (bus.redirect_valid) begin
          state_next_s = target_ok_s ? RUN : DRAIN;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state, PC and the registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pc_r    <= RESET_W;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= state_is_busy(state_next_s);
      done_r  <= (state_next_s == DONE);
      if (bus.redirect_valid) begin
        pc_r <= bus.redirect_pc;
      end else if (push_s) begin
        pc_r <= pc_r + N'(1'b1);
      end else begin
        pc_r <= pc_r;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed program-flow scenarios plus
// randomized handshake/redirect traffic against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int N     = 32;
  localparam int INS   = 10;
  localparam int DEPTH = 2;

  typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;

  imem_fetch_ctrl_if #(.N(N)) bus ();

  imem_fetch_ctrl #(
    .N(N), .INS(INS), .DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  logic [31:0] rom [16];
  assign bus.imem_instr = (bus.imem_pc < 32'(INS)) ? rom[bus.imem_pc[3:0]] : 32'hBAD0_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt;
  int total_cnt;

  // Reference model: program order as a queue of PCs, plus the fetch phase.
  phase_t      m_ph;
  logic [31:0] m_pc;
  logic [31:0] m_q [$];

  task automatic model_reset();
    m_ph = P_IDLE;
    m_pc = 32'd0;
    m_q.delete();
  endtask

  task automatic model_step();
    int pre_size;
    bit pop;
    pre_size = m_q.size();
    pop = (pre_size > 0) && bus.out_ready;
    if (rst) begin
      model_reset();
    end else if (bus.redirect_valid) begin
      m_q.delete();
      m_pc = bus.redirect_pc;
      if (m_ph != P_IDLE) m_ph = (bus.redirect_pc < 32'(INS)) ? P_RUN : P_DRAIN;
    end else begin
      if (pop) void'(m_q.pop_front());
      case (m_ph)
        P_IDLE:  if (start) m_ph = P_RUN;
        P_RUN: begin
          if (m_pc >= 32'(INS)) m_ph = P_DRAIN;
          else if (pre_size < DEPTH || pop) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd1;
          end
        end
        P_DRAIN: if (pre_size == 0) m_ph = P_DONE;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (bus.imem_pc !== 32'd0) $display("FAIL reset_imem_pc got %0h want 0", bus.imem_pc); else pass_cnt++;
    total_cnt++; if (bus.out_pc !== 32'd0) $display("FAIL reset_out_pc got %0h want 0", bus.out_pc); else pass_cnt++;
    total_cnt++; if (bus.out_instr !== 32'd0) $display("FAIL reset_out_instr got %0h want 0", bus.out_instr); else pass_cnt++;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    total_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_no_start got valid=%0b busy=%0b want 0/0", bus.out_valid, busy); else pass_cnt++;
  endtask

  task automatic test_straight_line();
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start();
    total_cnt++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL sl_start got busy=%0b valid=%0b want 1/0", busy, bus.out_valid); else pass_cnt++;
    for (int k = 0; k < INS; k++) begin
      tick();
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k) || bus.out_instr !== rom[k])
        $display("FAIL sl_word%0d got valid=%0b pc=%0h instr=%0h want 1/%0h/%0h", k, bus.out_valid, bus.out_pc, bus.out_instr, k, rom[k]);
      else pass_cnt++;
    end
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) $display("FAIL sl_drain got valid=%0b done=%0b busy=%0b want 0/0/1", bus.out_valid, done, busy); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL sl_done got done=%0b busy=%0b want 1/0", done, busy); else pass_cnt++;
    total_cnt++; if (bus.imem_pc !== 32'd10) $display("FAIL sl_end_pc got %0h want a", bus.imem_pc); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    do_reset();
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (5) tick();
    total_cnt++; if (bus.imem_pc !== 32'd2) $display("FAIL bp_hold_pc got %0h want 2", bus.imem_pc); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0) $display("FAIL bp_head got valid=%0b pc=%0h want 1/0", bus.out_valid, bus.out_pc); else pass_cnt++;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && done !== 1'b1; c++) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_pc);
      tick();
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL bp_timeout got done=%0b want 1", done); else pass_cnt++;
    total_cnt++; if (got.size() != INS) $display("FAIL bp_count got %0d want %0d", got.size(), INS); else pass_cnt++;
    for (int i = 0; i < got.size() && i < INS; i++) begin
      total_cnt++; if (got[i] !== 32'(i)) $display("FAIL bp_order%0d got %0h want %0h", i, got[i], i); else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.out_valid === 1'b1 && bus.out_pc === 32'd3) found = 1'b1;
      else tick();
    end
    total_cnt++; if (!found) $display("FAIL rd_wait_pc3 got none want pc 3 valid"); else pass_cnt++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd7;
    tick();
    bus.redirect_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.imem_pc !== 32'd7) $display("FAIL rd_flush got valid=%0b imem_pc=%0h want 0/7", bus.out_valid, bus.imem_pc); else pass_cnt++;
    for (int k = 7; k < INS; k++) begin
      tick();
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k)) $display("FAIL rd_word%0d got valid=%0b pc=%0h want 1/%0h", k, bus.out_valid, bus.out_pc, k); else pass_cnt++;
    end
    tick();
    tick();
    total_cnt++; if (done !== 1'b1) $display("FAIL rd_done got %0b want 1", done); else pass_cnt++;
  endtask

  task automatic test_redirect_oor_and_done();
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start();
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd12;
    tick();
    bus.redirect_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) $display("FAIL oor_drain got valid=%0b busy=%0b done=%0b want 0/1/0", bus.out_valid, busy, done); else pass_cnt++;
    total_cnt++; if (bus.imem_pc !== 32'd12) $display("FAIL oor_pc got %0h want c", bus.imem_pc); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL oor_done got done=%0b busy=%0b valid=%0b want 1/0/0", done, busy, bus.out_valid); else pass_cnt++;
    pulse_start();
    total_cnt++; if (done !== 1'b1) $display("FAIL done_ignores_start got %0b want 1", done); else pass_cnt++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd4;
    tick();
    bus.redirect_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL fd_run got busy=%0b done=%0b want 1/0", busy, done); else pass_cnt++;
    for (int k = 4; k < INS; k++) begin
      tick();
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k) || bus.out_instr !== rom[k]) $display("FAIL fd_word%0d got valid=%0b pc=%0h want 1/%0h", k, bus.out_valid, bus.out_pc, k); else pass_cnt++;
    end
    tick();
    tick();
    total_cnt++; if (done !== 1'b1) $display("FAIL fd_done got %0b want 1", done); else pass_cnt++;
  endtask

  task automatic test_midrun_reset();
    do_reset();
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (3) tick();
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.imem_pc !== 32'd2) $display("FAIL mr_full got valid=%0b imem_pc=%0h want 1/2", bus.out_valid, bus.imem_pc); else pass_cnt++;
    rst = 1'b1;
    model_reset();
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.imem_pc !== 32'd0) $display("FAIL mr_async got valid=%0b busy=%0b imem_pc=%0h want 0/0/0", bus.out_valid, busy, bus.imem_pc); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    total_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mr_needs_start got valid=%0b busy=%0b want 0/0", bus.out_valid, busy); else pass_cnt++;
    pulse_start();
    tick();
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0) $display("FAIL mr_resume got valid=%0b pc=%0h want 1/0", bus.out_valid, bus.out_pc); else pass_cnt++;
  endtask

  task automatic test_random();
    bit exp_valid;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'($urandom_range(0, 5));
    tick();
    bus.redirect_valid = 1'b0;
    pulse_start();
    for (int c = 0; c < 600; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc = 32'($urandom_range(0, 12));
      start = ($urandom_range(0, 9) == 0);
      tick();
      exp_valid = (m_q.size() != 0);
      total_cnt++; if (bus.out_valid !== exp_valid) $display("FAIL rnd_valid c%0d got %0b want %0b", c, bus.out_valid, exp_valid); else pass_cnt++;
      if (exp_valid) begin
        total_cnt++;
        if (bus.out_pc !== m_q[0] || bus.out_instr !== rom[m_q[0][3:0]])
          $display("FAIL rnd_head c%0d got pc=%0h instr=%0h want %0h/%0h", c, bus.out_pc, bus.out_instr, m_q[0], rom[m_q[0][3:0]]);
        else pass_cnt++;
      end
      total_cnt++; if (bus.imem_pc !== m_pc) $display("FAIL rnd_pc c%0d got %0h want %0h", c, bus.imem_pc, m_pc); else pass_cnt++;
      total_cnt++;
      if (busy !== (m_ph == P_RUN || m_ph == P_DRAIN) || done !== (m_ph == P_DONE))
        $display("FAIL rnd_status c%0d got busy=%0b done=%0b want phase %0d", c, busy, done, m_ph);
      else pass_cnt++;
    end
    start = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    for (int i = 0; i < 16; i++) rom[i] = $urandom();
    model_reset();
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_redirect_oor_and_done();
    test_midrun_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
